// File: rtl/rlc_game_pio_pkg.sv
// Shared definitions for the game PIO front-ends.
//   - Avalon-MM word addresses of the DataIn sampler register map
//   - bit positions of the status and control register fields
//   - debounce FSM state encoding
package rlc_game_pio_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DBPER  = 2'd3;

  localparam int STAT_CNT_LSB   = 16;
  localparam int STAT_EMPTY_BIT = 24;
  localparam int STAT_FULL_BIT  = 25;
  localparam int STAT_OVF_BIT   = 26;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int CTRL_FLUSH_BIT = 2;

  typedef enum logic [1:0] {
    STABLE = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/rlc_game_event_fifo.sv
// Synchronous first-word-fall-through event FIFO.
//   clk, reset   : clock, synchronous active-high reset
//   push_i       : write data_i (accepted when not full, or when a pop
//                  happens in the same cycle)
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : empty the FIFO; beats push and pop in the same cycle
//   data_o       : head entry, valid while empty_o is low
//   count_o      : number of stored entries, 0..DEPTH
//   empty_o/full_o
// Overflow bookkeeping is the parent's job; a refused push is just lost.
module rlc_game_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t wr_ptr_q, rd_ptr_q;
  cnt_t count_q;
  logic do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == cnt_t'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !reset) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rlc_game_datain_sampler.sv
// Sequencing front-end for the game DataIn port.
// Synchronizes in_port through two flops, debounces every change over
// db_period+1 stable samples, and queues each committed value in an event
// FIFO read through an Avalon-MM slave with a level interrupt.
//   clk, reset            : clock, synchronous active-high reset
//   address/read/write/
//   writedata/readdata    : Avalon-MM slave, readdata registered (1 cycle)
//   in_port               : raw asynchronous input
//   irq                   : level interrupt, irq_en & (!empty | ovf), registered
// Register map: 0 data (read pops), 1 status, 2 ctrl, 3 debounce period.
// Optional macro RLC_DATAIN_TIMESTAMP_EN: each entry carries a 16-bit
// free-running cycle stamp, returned in data[31:16].
module rlc_game_datain_sampler
  import rlc_game_pio_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DB_RESET   = 16'd1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef RLC_DATAIN_TIMESTAMP_EN
  localparam int ENTRY_W = WIDTH + 16;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  logic [WIDTH-1:0]   sync1_q, sync_q, stable_q, stable_d, cand_q, cand_d;
  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d, db_period_q;
  logic               enable_q, irq_en_q, ovf_q, irq_q;
  logic [31:0]        readdata_q, readdata_d;
  logic               commit_push, push_eff, pop_req, flush, ovf_set;
  logic               wr_status, wr_ctrl, wr_dbper;
  logic [ENTRY_W-1:0] push_data, head;
  logic [CW-1:0]      count;
  logic               empty, full;
  logic               unused_wd;

  assign unused_wd = ^{writedata[31:27], writedata[25:16]};

  assign wr_status = write && (address == ADDR_STATUS);
  assign wr_ctrl   = write && (address == ADDR_CTRL);
  assign wr_dbper  = write && (address == ADDR_DBPER);
  assign flush     = wr_ctrl && writedata[CTRL_FLUSH_BIT];
  assign pop_req   = read && (address == ADDR_DATA);
  assign push_eff  = commit_push && !flush;
  // A push into a full FIFO is only lost when no pop frees a slot.
  assign ovf_set   = push_eff && full && !pop_req;

`ifdef RLC_DATAIN_TIMESTAMP_EN
  logic [15:0] ts_q;
  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 16'd1;
  end
  assign push_data = {ts_q, cand_q};
`else
  assign push_data = cand_q;
`endif

  // Debounce FSM. A candidate that falls back to the committed value
  // before settling is a glitch: abandon it rather than re-commit.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    stable_d    = stable_q;
    commit_push = 1'b0;
    if (!enable_q) begin
      state_d  = STABLE;
      stable_d = sync_q;
    end else begin
      case (state_q)
        STABLE: begin
          if (sync_q != stable_q) begin
            cand_d  = sync_q;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (sync_q != cand_q) begin
            if (sync_q == stable_q) begin
              state_d = STABLE;
            end else begin
              cand_d = sync_q;
              cnt_d  = '0;
            end
          end else if (cnt_q == db_period_q) begin
            state_d = COMMIT;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        COMMIT: begin
          stable_d    = cand_q;
          commit_push = 1'b1;
          state_d     = STABLE;
        end
        default: state_d = STABLE;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: begin
        if (!empty) begin
          readdata_d[WIDTH-1:0] = head[WIDTH-1:0];
`ifdef RLC_DATAIN_TIMESTAMP_EN
          readdata_d[31:16] = head[ENTRY_W-1:WIDTH];
`endif
        end
      end
      ADDR_STATUS: begin
        readdata_d[WIDTH-1:0]            = stable_q;
        readdata_d[STAT_CNT_LSB +: CW]   = count;
        readdata_d[STAT_EMPTY_BIT]       = empty;
        readdata_d[STAT_FULL_BIT]        = full;
        readdata_d[STAT_OVF_BIT]         = ovf_q;
      end
      ADDR_CTRL: begin
        readdata_d[CTRL_EN_BIT]    = enable_q;
        readdata_d[CTRL_IRQEN_BIT] = irq_en_q;
      end
      default: readdata_d[15:0] = db_period_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      state_q     <= STABLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      stable_q    <= '0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      db_period_q <= DB_RESET;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      sync1_q  <= in_port;
      sync_q   <= sync1_q;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      if (wr_ctrl) begin
        enable_q <= writedata[CTRL_EN_BIT];
        irq_en_q <= writedata[CTRL_IRQEN_BIT];
      end
      if (wr_dbper) db_period_q <= writedata[15:0];
      if (ovf_set) ovf_q <= 1'b1;
      else if (wr_status && writedata[STAT_OVF_BIT]) ovf_q <= 1'b0;
      irq_q      <= irq_en_q && (!empty || ovf_q);
      readdata_q <= readdata_d;
    end
  end

  rlc_game_event_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_eff),
    .pop_i   (pop_req),
    .flush_i (flush),
    .data_i  (push_data),
    .data_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
